// File: rtl/alu_issue_stage.sv
// Execute-issue stage: decodes op class/funct into ALU control and operands, registered, 1-cycle latency.
// Two-entry skid (output reg + skid reg); in_ready is registered and never depends on out_ready.
module alu_issue_stage #(
  parameter int          DATA_W       = 32,
  parameter logic [3:0]  ILLEGAL_CTRL = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op_class,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_illegal
);

  logic              out_valid_q, out_valid_d;
  logic [3:0]        out_ctrl_q, out_ctrl_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic              out_illegal_q, out_illegal_d;
  logic              skid_valid_q, skid_valid_d;
  logic [3:0]        skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  logic              skid_illegal_q, skid_illegal_d;
  logic              in_ready_q, in_ready_d;

  logic [3:0]        dec_ctrl;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic              dec_illegal;
  logic              xfer_in, xfer_out;

  assign xfer_in  = in_valid & in_ready_q;
  assign xfer_out = out_valid_q & out_ready;

  always_comb begin
    dec_ctrl    = ILLEGAL_CTRL;
    dec_a       = in_rs_data;
    dec_b       = in_rt_data;
    dec_illegal = 1'b0;
    case (in_op_class)
      2'b00: begin
        case (in_funct)
          6'h20: dec_ctrl = 4'b0010;
          6'h22: dec_ctrl = 4'b0011;
          6'h24: dec_ctrl = 4'b0000;
          6'h25: dec_ctrl = 4'b0001;
          6'h27: dec_ctrl = 4'b0101;
          6'h2A: dec_ctrl = 4'b0100;
          6'h00, 6'h02: begin
            // Shifts operate on rt; rs is not an operand.
            dec_ctrl = (in_funct == 6'h00) ? 4'b1000 : 4'b1001;
            dec_a    = in_rt_data;
            dec_b    = {{(DATA_W-5){1'b0}}, in_shamt};
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b01: begin
        dec_ctrl = 4'b0010;
        dec_b    = {{(DATA_W-16){in_imm[15]}}, in_imm};
      end
      2'b10: begin
        dec_ctrl = 4'b0000;
        dec_b    = {{(DATA_W-16){1'b0}}, in_imm};
      end
      default: begin
        dec_ctrl = 4'b0001;
        dec_b    = {{(DATA_W-16){1'b0}}, in_imm};
      end
    endcase
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_ctrl_d     = out_ctrl_q;
    out_a_d        = out_a_q;
    out_b_d        = out_b_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_ctrl_d    = skid_ctrl_q;
    skid_a_d       = skid_a_q;
    skid_b_d       = skid_b_q;
    skid_illegal_d = skid_illegal_q;
    // A full skid forces in_ready low, so xfer_in cannot coincide with the skid refill path.
    if (xfer_out && skid_valid_q) begin
      out_ctrl_d    = skid_ctrl_q;
      out_a_d       = skid_a_q;
      out_b_d       = skid_b_q;
      out_illegal_d = skid_illegal_q;
      skid_valid_d  = 1'b0;
    end else if (xfer_in && (!out_valid_q || xfer_out)) begin
      out_valid_d   = 1'b1;
      out_ctrl_d    = dec_ctrl;
      out_a_d       = dec_a;
      out_b_d       = dec_b;
      out_illegal_d = dec_illegal;
    end else if (xfer_in) begin
      skid_valid_d   = 1'b1;
      skid_ctrl_d    = dec_ctrl;
      skid_a_d       = dec_a;
      skid_b_d       = dec_b;
      skid_illegal_d = dec_illegal;
    end else if (xfer_out) begin
      out_valid_d = 1'b0;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_ctrl_q     <= 4'b0000;
      out_a_q        <= '0;
      out_b_q        <= '0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_ctrl_q    <= 4'b0000;
      skid_a_q       <= '0;
      skid_b_q       <= '0;
      skid_illegal_q <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      out_valid_q    <= out_valid_d;
      out_ctrl_q     <= out_ctrl_d;
      out_a_q        <= out_a_d;
      out_b_q        <= out_b_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_ctrl_q    <= skid_ctrl_d;
      skid_a_q       <= skid_a_d;
      skid_b_q       <= skid_b_d;
      skid_illegal_q <= skid_illegal_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, skid backpressure, ordering and async reset.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op_class;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_ctrl;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_illegal;

  int vectors = 0;
  int miscompares = 0;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op_class(in_op_class), .in_funct(in_funct), .in_shamt(in_shamt),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_a(out_a), .out_b(out_b), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [1:0] cls, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [15:0] imm);
    in_valid    = vld;
    in_op_class = cls;
    in_funct    = fn;
    in_shamt    = sh;
    in_rs_data  = rs;
    in_rt_data  = rt;
    in_imm      = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [3:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b, input logic ill);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, vld});
    chk({tag, ".ctrl"}, {28'b0, out_ctrl}, {28'b0, ctrl});
    chk({tag, ".a"}, out_a, a);
    chk({tag, ".b"}, out_b, b);
    chk({tag, ".illegal"}, {31'b0, out_illegal}, {31'b0, ill});
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    #1;
    chk_out("reset", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("reset.in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    tick();
    rst = 1'b0;

    // Basic R-type decode, out_ready held high
    drive(1'b1, 2'b00, 6'h20, 5'd0, 32'd5, 32'd7, 16'h0);
    tick();
    chk_out("add", 1'b1, 4'b0010, 32'd5, 32'd7, 1'b0);
    drive(1'b1, 2'b00, 6'h00, 5'd4, 32'hDEAD, 32'h1, 16'h0);
    tick();
    chk_out("sll", 1'b1, 4'b1000, 32'h1, 32'h4, 1'b0);
    drive(1'b1, 2'b00, 6'h02, 5'd3, 32'hBEEF, 32'hF0, 16'h0);
    tick();
    chk_out("srl", 1'b1, 4'b1001, 32'hF0, 32'h3, 1'b0);
    drive(1'b1, 2'b00, 6'h22, 5'd0, 32'd9, 32'd3, 16'h0);
    tick();
    chk_out("sub", 1'b1, 4'b0011, 32'd9, 32'd3, 1'b0);
    drive(1'b1, 2'b00, 6'h27, 5'd0, 32'h12, 32'h34, 16'h0);
    tick();
    chk_out("nor", 1'b1, 4'b0101, 32'h12, 32'h34, 1'b0);
    drive(1'b1, 2'b00, 6'h2A, 5'd0, 32'h56, 32'h78, 16'h0);
    tick();
    chk_out("slt", 1'b1, 4'b0100, 32'h56, 32'h78, 1'b0);

    // Immediates: sign- vs zero-extension
    drive(1'b1, 2'b01, 6'h00, 5'd0, 32'd10, 32'h0, 16'hFFFE);
    tick();
    chk_out("addi", 1'b1, 4'b0010, 32'd10, 32'hFFFFFFFE, 1'b0);
    drive(1'b1, 2'b11, 6'h00, 5'd0, 32'd1, 32'h0, 16'h8000);
    tick();
    chk_out("ori", 1'b1, 4'b0001, 32'd1, 32'h00008000, 1'b0);
    drive(1'b1, 2'b10, 6'h00, 5'd0, 32'd3, 32'h0, 16'h8001);
    tick();
    chk_out("andi", 1'b1, 4'b0000, 32'd3, 32'h00008001, 1'b0);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    tick();
    chk_out("empty_hold", 1'b0, 4'b0000, 32'd3, 32'h00008001, 1'b0);

    // Backpressure: third entry refused, outputs stable, ordered drain
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 6'h20, 5'd0, 32'd1, 32'd11, 16'h0);
    tick();
    chk_out("bp.e1", 1'b1, 4'b0010, 32'd1, 32'd11, 1'b0);
    chk("bp.rdy1", {31'b0, in_ready}, 32'h1);
    drive(1'b1, 2'b00, 6'h20, 5'd0, 32'd2, 32'd22, 16'h0);
    tick();
    chk("bp.rdy2", {31'b0, in_ready}, 32'h0);
    chk_out("bp.hold1", 1'b1, 4'b0010, 32'd1, 32'd11, 1'b0);
    drive(1'b1, 2'b00, 6'h20, 5'd0, 32'd3, 32'd33, 16'h0);
    tick();
    chk("bp.rdy3", {31'b0, in_ready}, 32'h0);
    chk_out("bp.hold2", 1'b1, 4'b0010, 32'd1, 32'd11, 1'b0);
    out_ready = 1'b1;
    tick();
    chk_out("drain.e2", 1'b1, 4'b0010, 32'd2, 32'd22, 1'b0);
    chk("drain.rdy", {31'b0, in_ready}, 32'h1);
    tick();
    chk_out("drain.e3", 1'b1, 4'b0010, 32'd3, 32'd33, 1'b0);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    tick();
    chk("drain.empty", {31'b0, out_valid}, 32'h0);

    // Unsupported funct flows through flagged; the next entry is clean
    drive(1'b1, 2'b00, 6'h3F, 5'd0, 32'h11, 32'h22, 16'h0);
    tick();
    chk_out("illegal", 1'b1, 4'b1111, 32'h11, 32'h22, 1'b1);
    drive(1'b1, 2'b00, 6'h25, 5'd0, 32'h1, 32'h2, 16'h0);
    tick();
    chk_out("after_ill", 1'b1, 4'b0001, 32'h1, 32'h2, 1'b0);

    // Async reset with both entries held
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 6'h20, 5'd0, 32'hAA, 32'h1, 16'h0);
    tick();
    drive(1'b1, 2'b00, 6'h20, 5'd0, 32'hBB, 32'h2, 16'h0);
    tick();
    chk("rst.full", {31'b0, in_ready}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst.async", 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'h1);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst.no_stale", {31'b0, out_valid}, 32'h0);
    drive(1'b1, 2'b00, 6'h24, 5'd0, 32'hCC, 32'hDD, 16'h0);
    tick();
    chk_out("rst.fresh", 1'b1, 4'b0000, 32'hCC, 32'hDD, 1'b0);
    drive(1'b0, 2'b00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
